datapath_mux: RTL and testbench
===============================

Name: datapath_mux

Overview:
- Arithmetic datapath that executes the select/strobe sequence emitted by the ControlMux sequencer (the consumer end of that control interface).
- Latches an input sample and performs one signed fixed-point multiply-accumulate per clock, using the selected constant and operand.
- Commits the filter result fk on the sequencer's done strobe, maintains fk history, and presents the result through a valid/ready output.

Parameters:
- W, 16, data/constant width (signed two's complement, Q(W-F).F)
- F, 8, fractional bits
- K0, 16'sh0100, constant for sel_const=0 (+1.0)
- K1, 16'sh0080, constant for sel_const=1 (+0.5)
- K2, 16'shFF00, constant for sel_const=2 (-1.0)
- K3, 16'sh0040, constant for sel_const=3 (+0.25)
- K4, 16'sh0020, constant for sel_const=4 (+0.125)

Ports:
- clk  in  1  system clock, all registers on rising edge
- reset  in  1  asynchronous, active-high; clears every register
- Bandera  in  1  per-sample start; synchronous clear of acc, x_reg and the Listo edge detector
- sel_const  in  3  constant select
- sel_fun  in  2  operand select
- sel_acum  in  2  accumulator operation
- Senal  in  1  sample-capture strobe
- Band_Listo  in  1  sequence-done level from the sequencer
- dato_in  in  W  signed input sample
- y_out  out  W  committed result fk
- y_valid  out  1  y_out holds an unconsumed result
- y_ready  in  1  downstream accepts y_out when y_valid&y_ready
- sat_flag  out  1  sticky: any saturation since reset
- overrun  out  1  sticky: a commit overwrote an unconsumed result

Behaviour:
- Reset: x_reg, acc, fk_1, fk_2, y_out = 0; y_valid, sat_flag, overrun = 0; listo_q = 0.
- Constant mux: sel_const 0..4 -> K0..K4; 5..7 -> 0.
- Operand mux: sel_fun 00 -> x_reg; 01 -> acc; 10 -> fk_1; 11 -> fk_2.
- Product: full 2W signed product, shifted right by F with rounding half away from zero, then saturated to the W range [-2^(W-1), 2^(W-1)-1]. Saturation sets sat_flag.
- Sum: acc + prod is computed at W+1 bits, then saturated to W. Saturation sets sat_flag.
- acc_next by sel_acum:
  - 00 -> 0
  - 01 -> sat(acc+prod)
  - 10 -> prod (load)
  - 11 -> acc (hold)
- acc <= acc_next every cycle unless Bandera=1, in which case acc <= 0.
- Senal=1: x_reg <= dato_in at that edge. The new value is usable as an operand from the next cycle. When Bandera=1, x_reg <= 0 and Senal is ignored.
- Commit condition: Band_Listo=1 & listo_q=0 & Bandera=0 (rising edge only). Band_Listo held high for several cycles commits once.
- listo_q <= Band_Listo each cycle; Bandera forces listo_q <= 0.
- On commit at edge t:
  - y_out <= acc_next, fk_1 <= acc_next, fk_2 <= old fk_1.
  - acc is still updated with acc_next.
  - y_valid=1 from t onward.
- Handshake: y_valid clears at an edge where y_valid&y_ready and no commit occurs.
- Commit with y_valid=1 & y_ready=0: y_out is overwritten and overrun <= 1.
- Commit with y_valid=1 & y_ready=1: the old value counts as consumed and y_valid stays 1; no overrun.
- Bandera with Band_Listo high in the same cycle: Bandera wins; no commit and no history update.
- Bandera does not clear fk_1, fk_2, y_out, y_valid or the sticky flags; only reset does.
- Reset mid-sequence returns all state to reset values immediately. Any partial sum is lost.
- Latency: Senal sample -> first usable MAC is 1 cycle. Final MAC cycle = commit cycle, so y_valid rises at the same edge that applies the last accumulate.

Test Plan:
- Reset, then Senal=1 with dato_in=0x0200. Next cycle: sel_const=1, sel_fun=00, sel_acum=10 -> acc=0x0100. Then sel_const=0, sel_fun=01, sel_acum=01 -> acc=0x0200. Then Band_Listo=1, sel_acum=11 -> y_out=0x0200, y_valid=1, fk_1=0x0200, fk_2=0.
- Hold Band_Listo high 3 cycles with y_ready=1 -> exactly one commit; y_valid pulses for 1 cycle.
- Rounding: K1 (0.5) × x_reg=0x0001 loaded -> acc=0x0001. With x_reg=0xFFFF -> acc=0xFFFF.
- Saturation: K0 × x_reg=0x7FFF, then acc+=K0×x_reg -> acc=0x7FFF, sat_flag=1 and stays 1 after Bandera.
- Two commits with y_ready=0 -> second y_out is visible, overrun=1. Second sample's sel_fun=10 with K0 reads previous fk_1.
- Bandera and Band_Listo asserted together -> no commit, acc=0, history unchanged. Assert reset mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/datapath_mux.sv
// Signed fixed-point MAC datapath driven by the ControlMux select/strobe sequence; one MAC per clock.
// Result commits on the rising edge of Band_Listo (0-cycle extra latency); y_out is overwritten if unconsumed (overrun).
module datapath_mux #(
  parameter int W = 16,
  parameter int F = 8,
  parameter logic signed [W-1:0] K0 = 16'sh0100,
  parameter logic signed [W-1:0] K1 = 16'sh0080,
  parameter logic signed [W-1:0] K2 = 16'shFF00,
  parameter logic signed [W-1:0] K3 = 16'sh0040,
  parameter logic signed [W-1:0] K4 = 16'sh0020
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Bandera,
  input  logic [2:0]          sel_const,
  input  logic [1:0]          sel_fun,
  input  logic [1:0]          sel_acum,
  input  logic                Senal,
  input  logic                Band_Listo,
  input  logic signed [W-1:0] dato_in,
  output logic signed [W-1:0] y_out,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                sat_flag,
  output logic                overrun
);

  localparam logic signed [W-1:0]   SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W:0]   PMAX = (2*W+1)'(2**(W-1) - 1);
  localparam logic signed [2*W:0]   PMIN = (2*W+1)'(-(2**(W-1)));
  localparam logic [2*W-1:0]        HALF = (2*W)'(1) << (F-1);

  logic signed [W-1:0]   x_reg, acc, fk_1, fk_2;
  logic signed [W-1:0]   k_sel, op_sel, prod, sum_sat, acc_next;
  logic signed [2*W-1:0] prod_full;
  logic [2*W-1:0]        prod_mag, rnd_sum, rnd_mag;
  logic signed [2*W:0]   rnd_val;
  logic signed [W:0]     sum_full;
  logic                  prod_neg, prod_ovf, sum_ovf, sat_hit, listo_q, commit;

  always_comb begin
    case (sel_const)
      3'd0:    k_sel = K0;
      3'd1:    k_sel = K1;
      3'd2:    k_sel = K2;
      3'd3:    k_sel = K3;
      3'd4:    k_sel = K4;
      default: k_sel = '0;
    endcase
    case (sel_fun)
      2'b00:   op_sel = x_reg;
      2'b01:   op_sel = acc;
      2'b10:   op_sel = fk_1;
      default: op_sel = fk_2;
    endcase
  end

  // Round half away from zero by rounding the magnitude and restoring the sign.
  always_comb begin
    prod_full = k_sel * op_sel;
    prod_neg  = prod_full[2*W-1];
    prod_mag  = prod_neg ? $unsigned(-prod_full) : $unsigned(prod_full);
    rnd_sum   = prod_mag + HALF;
    rnd_mag   = rnd_sum >> F;
    rnd_val   = prod_neg ? -$signed({1'b0, rnd_mag}) : $signed({1'b0, rnd_mag});
    prod_ovf  = (rnd_val > PMAX) || (rnd_val < PMIN);
    if (rnd_val > PMAX)      prod = SMAX;
    else if (rnd_val < PMIN) prod = SMIN;
    else                     prod = rnd_val[W-1:0];
  end

  always_comb begin
    sum_full = {acc[W-1], acc} + {prod[W-1], prod};
    sum_ovf  = sum_full[W] != sum_full[W-1];
    if (sum_ovf) sum_sat = sum_full[W] ? SMIN : SMAX;
    else         sum_sat = sum_full[W-1:0];
    case (sel_acum)
      2'b00:   acc_next = '0;
      2'b01:   acc_next = sum_sat;
      2'b10:   acc_next = prod;
      default: acc_next = acc;
    endcase
  end

  // Saturation only counts when the saturated value actually lands in acc.
  assign sat_hit = !Bandera && (((sel_acum == 2'b01) && (prod_ovf || sum_ovf)) ||
                                ((sel_acum == 2'b10) && prod_ovf));
  assign commit  = Band_Listo && !listo_q && !Bandera;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg    <= '0;
      acc      <= '0;
      fk_1     <= '0;
      fk_2     <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
      overrun  <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      listo_q <= Bandera ? 1'b0 : Band_Listo;
      acc     <= Bandera ? '0 : acc_next;
      if (Bandera)    x_reg <= '0;
      else if (Senal) x_reg <= dato_in;
      if (sat_hit) sat_flag <= 1'b1;
      if (commit) begin
        y_out   <= acc_next;
        fk_1    <= acc_next;
        fk_2    <= fk_1;
        y_valid <= 1'b1;
        if (y_valid && !y_ready) overrun <= 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_datapath_mux.sv
// Randomized and directed bench for datapath_mux against an arithmetic reference model.
module tb_datapath_mux;

  logic               clk = 1'b0;
  logic               reset;
  logic               Bandera, Senal, Band_Listo, y_ready;
  logic [2:0]         sel_const;
  logic [1:0]         sel_fun, sel_acum;
  logic signed [15:0] dato_in, y_out;
  logic               y_valid, sat_flag, overrun;

  datapath_mux dut (
    .clk(clk), .reset(reset), .Bandera(Bandera), .sel_const(sel_const),
    .sel_fun(sel_fun), .sel_acum(sel_acum), .Senal(Senal), .Band_Listo(Band_Listo),
    .dato_in(dato_in), .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state, kept as plain integers
  int mx, macc, mf1, mf2, my;
  bit myv, msat, movr, mlisto;
  int kt[8] = '{256, 128, -256, 64, 32, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int round_q(input int p);
    if (p >= 0) return (p + 128) / 256;
    return -((-p + 128) / 256);
  endfunction

  function automatic logic [31:0] u16(input int v);
    return 32'(v) & 32'h0000FFFF;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".y_out"},    {16'b0, y_out},   u16(my));
    check({tag, ".y_valid"},  {31'b0, y_valid}, {31'b0, myv});
    check({tag, ".sat_flag"}, {31'b0, sat_flag}, {31'b0, msat});
    check({tag, ".overrun"},  {31'b0, overrun}, {31'b0, movr});
    check({tag, ".acc"},      {16'b0, dut.acc}, u16(macc));
  endtask

  task automatic model_clear();
    mx = 0; macc = 0; mf1 = 0; mf2 = 0; my = 0;
    myv = 0; msat = 0; movr = 0; mlisto = 0;
  endtask

  task automatic step(input string tag, input bit band, input int sc, input int sf, input int sa,
                      input bit sen, input bit bl, input int din, input bit yr);
    int op, p, r, prod, s, sum, nxt;
    bit psat, ssat, commit;
    logic signed [15:0] d16;
    d16 = 16'(din);
    Bandera = band; sel_const = 3'(sc); sel_fun = 2'(sf); sel_acum = 2'(sa);
    Senal = sen; Band_Listo = bl; dato_in = d16; y_ready = yr;
    case (sf)
      0: op = mx;
      1: op = macc;
      2: op = mf1;
      default: op = mf2;
    endcase
    p = kt[sc] * op;
    r = round_q(p);
    prod = clamp16(r);
    psat = (prod != r);
    s = macc + prod;
    sum = clamp16(s);
    ssat = (sum != s);
    case (sa)
      0: nxt = 0;
      1: nxt = sum;
      2: nxt = prod;
      default: nxt = macc;
    endcase
    if (!band && ((sa == 1 && (psat || ssat)) || (sa == 2 && psat))) msat = 1;
    commit = bl && !mlisto && !band;
    if (commit) begin
      if (myv && !yr) movr = 1;
      my = nxt; mf2 = mf1; mf1 = nxt; myv = 1;
    end else if (myv && yr) begin
      myv = 0;
    end
    macc = band ? 0 : nxt;
    if (band) mx = 0;
    else if (sen) mx = d16;
    mlisto = band ? 1'b0 : bl;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit yr);
    step(tag, 0, 0, 0, 3, 0, 0, 0, yr);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Bandera = 0; sel_const = 0; sel_fun = 0; sel_acum = 0;
    Senal = 0; Band_Listo = 0; dato_in = 0; y_ready = 0;
    model_clear();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Basic sample: 0.5*2.0 = 1.0, then +1.0*acc = 2.0, commit 2.0
    step("t1_cap",  0, 0, 0, 3, 1, 0, 16'h0200, 0);
    step("t1_load", 0, 1, 0, 2, 0, 0, 0, 0);
    check("t1_acc_half", {16'b0, dut.acc}, 32'h0100);
    step("t1_add",  0, 0, 1, 1, 0, 0, 0, 0);
    step("t1_done", 0, 0, 0, 3, 0, 1, 0, 0);
    check("t1_y_out", {16'b0, y_out}, 32'h0200);
    check("t1_valid", {31'b0, y_valid}, 32'h1);

    // Held Band_Listo commits once; y_valid pulses
    idle("t2_drop", 1);
    step("t2_bl0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("t2_bl1", 0, 0, 0, 3, 0, 1, 0, 1);
    step("t2_bl2", 0, 0, 0, 3, 0, 1, 0, 1);
    check("t2_pulse_gone", {31'b0, y_valid}, 32'h0);

    // Rounding half away from zero
    step("t3_clr",  1, 0, 0, 0, 0, 0, 0, 0);
    step("t3_cap",  0, 0, 0, 3, 1, 0, 16'h0001, 0);
    step("t3_load", 0, 1, 0, 2, 0, 0, 0, 0);
    check("t3_rnd_pos", {16'b0, dut.acc}, 32'h0001);
    step("t3_capn", 0, 0, 0, 3, 1, 0, 16'hFFFF, 0);
    step("t3_loadn", 0, 1, 0, 2, 0, 0, 0, 0);
    check("t3_rnd_neg", {16'b0, dut.acc}, 32'hFFFF);

    // Saturating accumulate, sticky across Bandera
    step("t4_cap",  0, 0, 0, 3, 1, 0, 16'h7FFF, 0);
    step("t4_load", 0, 0, 0, 2, 0, 0, 0, 0);
    step("t4_add",  0, 0, 0, 1, 0, 0, 0, 0);
    check("t4_acc_sat", {16'b0, dut.acc}, 32'h7FFF);
    step("t4_band", 1, 0, 0, 0, 0, 0, 0, 0);
    check("t4_sat_sticky", {31'b0, sat_flag}, 32'h1);

    // Two unconsumed commits, second sample reads fk_1
    step("t5_cap",  0, 0, 0, 3, 1, 0, 16'h0100, 0);
    step("t5_load", 0, 0, 0, 2, 0, 0, 0, 0);
    step("t5_done", 0, 0, 0, 3, 0, 1, 0, 0);
    step("t5_band", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t5_cap2", 0, 0, 0, 3, 1, 0, 16'h0300, 0);
    step("t5_fk1",  0, 0, 2, 2, 0, 0, 0, 0);
    check("t5_fk1_read", {16'b0, dut.acc}, 32'h0100);
    step("t5_add",  0, 0, 0, 1, 0, 0, 0, 0);
    step("t5_done2", 0, 0, 0, 3, 0, 1, 0, 0);
    check("t5_y_out2", {16'b0, y_out}, 32'h0400);
    check("t5_overrun", {31'b0, overrun}, 32'h1);

    // Bandera beats Band_Listo
    idle("t6_idle", 1);
    step("t6_cap",  0, 0, 0, 3, 1, 0, 16'h0050, 1);
    step("t6_load", 0, 0, 0, 2, 0, 0, 0, 1);
    step("t6_both", 1, 0, 0, 2, 0, 1, 0, 1);
    check("t6_no_commit", {16'b0, y_out}, 32'h0400);
    check("t6_acc_zero", {16'b0, dut.acc}, 32'h0);

    // Reset mid-sequence
    step("t7_cap",  0, 0, 0, 3, 1, 0, 16'h1234, 0);
    step("t7_load", 0, 0, 0, 2, 0, 0, 0, 0);
    mid_reset();

    // Randomized control sequence
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           ($urandom_range(15) == 0), $urandom_range(7), $urandom_range(3), $urandom_range(3),
           $urandom_range(1), ($urandom_range(2) == 0), int'($urandom_range(16'hFFFF)),
           $urandom_range(1));
      if (i == 300) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
